// File: rtl/spad_frame_sequencer_pkg.sv
// Shared definitions for the SPAD frame sequencer: one-hot phase encodings and size defaults.
package spad_frame_sequencer_pkg;

   localparam int DEF_DUR_BITS       = 16;
   localparam int DEF_MIN_FRAME_CLKS = 6667;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_LATCH = 5'b00010,
      ST_PAUSE = 5'b00100,
      ST_RESET = 5'b01000,
      ST_READ  = 5'b10000
   } seq_state_e;

endpackage

// File: rtl/spad_frame_sequencer_phase_timer.sv
// spad_phase_timer: loadable down-counter shared by every frame phase; `last` marks the final clock.
module spad_phase_timer #(
   parameter int DUR_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [DUR_BITS-1:0] load_val,
   output logic                last,
   output logic [DUR_BITS-1:0] count
);

   logic [DUR_BITS-1:0] count_q, count_d;

   // Loading L leaves L-1 in the counter, so the phase spans exactly L clocks.
   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val - DUR_BITS'(1);
      else if (count_q != '0)
         count_d = count_q - DUR_BITS'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign last  = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/spad_frame_sequencer.sv
// SPAD frame sequencer: LATCH -> PAUSE -> RESET -> READ per frame, burst/continuous runs and
// frame-boundary config handshake. Define SPAD_SEQ_TIMESTAMP_EN to add the FrameTimestamp output.
module spad_frame_sequencer
   import spad_frame_sequencer_pkg::*;
#(
   parameter int DUR_BITS       = DEF_DUR_BITS,
   parameter int LATCH_CLKS     = 2,
   parameter int PAUSE_CLKS     = 1,
   parameter int RESET_CLKS     = 2,
   parameter int MIN_FRAME_CLKS = DEF_MIN_FRAME_CLKS,
   parameter int FRAME_ID_BITS  = 32,
   parameter int BURST_BITS     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Enable,
   input  logic                     BurstMode,
   input  logic [BURST_BITS-1:0]    BurstFrames,
   input  logic [DUR_BITS-1:0]      CfgFrameClks,
   input  logic                     CfgValid,
   output logic                     CfgReady,
   output logic                     CfgError,
   output logic                     LatchSpad,
   output logic                     ResetSpad,
   output logic                     ReadData,
   output logic                     FrameStart,
   output logic                     FrameDone,
   output logic [FRAME_ID_BITS-1:0] FrameId,
   output logic [DUR_BITS-1:0]      FrameDurationCurrentClks,
`ifdef SPAD_SEQ_TIMESTAMP_EN
   output logic [47:0]              FrameTimestamp,
`endif
   output logic                     Busy
);

   localparam logic [DUR_BITS-1:0] MIN_FRAME = DUR_BITS'(MIN_FRAME_CLKS);
   localparam logic [DUR_BITS-1:0] OVERHEAD  = DUR_BITS'(LATCH_CLKS + PAUSE_CLKS + RESET_CLKS);

   seq_state_e                state_q, state_d;
   logic [FRAME_ID_BITS-1:0]  frame_id_q, frame_id_d;
   logic [DUR_BITS-1:0]       cur_frame_q, cur_frame_d, pend_val_q, pend_val_d;
   logic                      pend_q, pend_d, cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
   logic                      burst_mode_q, burst_mode_d, burst_lock_q, burst_lock_d;
   logic [BURST_BITS-1:0]     burst_rem_q, burst_rem_d;
   logic                      latch_q, latch_d, rst_spad_q, rst_spad_d, read_q, read_d;
   logic                      start_q, start_d, done_q, done_d, busy_q, busy_d;
   logic                      apply, t_load, t_last;
   logic [DUR_BITS-1:0]       t_load_val, t_count;

   spad_phase_timer #(.DUR_BITS(DUR_BITS)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_load_val),
      .last     (t_last),
      .count    (t_count)
   );

   always_comb begin
      state_d      = state_q;
      frame_id_d   = frame_id_q;
      cur_frame_d  = cur_frame_q;
      pend_d       = pend_q;
      pend_val_d   = pend_val_q;
      cfg_ready_d  = cfg_ready_q;
      cfg_err_d    = 1'b0;
      burst_mode_d = burst_mode_q;
      burst_rem_d  = burst_rem_q;
      burst_lock_d = burst_lock_q;
      apply        = 1'b0;
      t_load       = 1'b0;
      t_load_val   = '0;
      case (state_q)
         ST_IDLE: begin
            apply = pend_q;
            if (!Enable) burst_lock_d = 1'b0;
            if (Enable && !burst_lock_q) begin
               state_d      = ST_LATCH;
               t_load       = 1'b1;
               t_load_val   = DUR_BITS'(LATCH_CLKS);
               burst_mode_d = BurstMode;
               burst_rem_d  = (BurstFrames == '0) ? BURST_BITS'(1) : BurstFrames;
            end
         end
         ST_LATCH: if (t_last) begin
            state_d = ST_PAUSE; t_load = 1'b1; t_load_val = DUR_BITS'(PAUSE_CLKS);
         end
         ST_PAUSE: if (t_last) begin
            state_d = ST_RESET; t_load = 1'b1; t_load_val = DUR_BITS'(RESET_CLKS);
         end
         ST_RESET: if (t_last) begin
            state_d = ST_READ; t_load = 1'b1; t_load_val = cur_frame_q - OVERHEAD;
         end
         ST_READ: if (t_last) begin
            frame_id_d = frame_id_q + FRAME_ID_BITS'(1);
            if (burst_mode_q) burst_rem_d = burst_rem_q - BURST_BITS'(1);
            // A finished burst locks out restart until Enable has been seen low.
            if (!Enable || (burst_mode_q && burst_rem_q == BURST_BITS'(1))) begin
               state_d      = ST_IDLE;
               burst_lock_d = Enable;
            end else begin
               state_d    = ST_LATCH;
               t_load     = 1'b1;
               t_load_val = DUR_BITS'(LATCH_CLKS);
               apply      = pend_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A changed frame length restarts numbering, overriding the FrameDone increment.
      if (apply) begin
         if (pend_val_q != cur_frame_q) frame_id_d = '0;
         cur_frame_d = pend_val_q;
         pend_d      = 1'b0;
         cfg_ready_d = 1'b1;
      end else if (CfgValid && cfg_ready_q) begin
         if (CfgFrameClks >= MIN_FRAME) begin
            pend_d      = 1'b1;
            pend_val_d  = CfgFrameClks;
            cfg_ready_d = 1'b0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      latch_d    = (state_d == ST_LATCH);
      rst_spad_d = (state_d == ST_RESET);
      read_d     = (state_d == ST_READ);
      busy_d     = (state_d != ST_IDLE);
      start_d    = (state_d == ST_LATCH) && (state_q != ST_LATCH);
      done_d     = (state_d == ST_READ) &&
                   (t_load ? (t_load_val == DUR_BITS'(1)) : (t_count == DUR_BITS'(1)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         frame_id_q   <= '0;
         cur_frame_q  <= MIN_FRAME;
         pend_q       <= 1'b0;
         pend_val_q   <= '0;
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= 1'b0;
         burst_mode_q <= 1'b0;
         burst_rem_q  <= '0;
         burst_lock_q <= 1'b0;
         latch_q      <= 1'b0;
         rst_spad_q   <= 1'b0;
         read_q       <= 1'b0;
         start_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_id_q   <= frame_id_d;
         cur_frame_q  <= cur_frame_d;
         pend_q       <= pend_d;
         pend_val_q   <= pend_val_d;
         cfg_ready_q  <= cfg_ready_d;
         cfg_err_q    <= cfg_err_d;
         burst_mode_q <= burst_mode_d;
         burst_rem_q  <= burst_rem_d;
         burst_lock_q <= burst_lock_d;
         latch_q      <= latch_d;
         rst_spad_q   <= rst_spad_d;
         read_q       <= read_d;
         start_q      <= start_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

`ifdef SPAD_SEQ_TIMESTAMP_EN
   logic [47:0] ts_cnt_q, ts_cnt_d, frame_ts_q, frame_ts_d;

   always_comb begin
      ts_cnt_d   = ts_cnt_q + 48'd1;
      frame_ts_d = start_d ? ts_cnt_q : frame_ts_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_cnt_q   <= '0;
         frame_ts_q <= '0;
      end else begin
         ts_cnt_q   <= ts_cnt_d;
         frame_ts_q <= frame_ts_d;
      end
   end

   assign FrameTimestamp = frame_ts_q;
`endif

   assign CfgReady                 = cfg_ready_q;
   assign CfgError                 = cfg_err_q;
   assign LatchSpad                = latch_q;
   assign ResetSpad                = rst_spad_q;
   assign ReadData                 = read_q;
   assign FrameStart               = start_q;
   assign FrameDone                = done_q;
   assign FrameId                  = frame_id_q;
   assign FrameDurationCurrentClks = cur_frame_q;
   assign Busy                     = busy_q;

endmodule

// File: tb/tb_spad_frame_sequencer.sv
// Directed bench for spad_frame_sequencer with a 20-clock minimum frame (2+1+2 phases, 15-clock READ).
module tb_spad_frame_sequencer;

   logic        clk, reset, Enable, BurstMode, CfgValid;
   logic [15:0] BurstFrames, CfgFrameClks, FrameDurationCurrentClks;
   logic        CfgReady, CfgError, LatchSpad, ResetSpad, ReadData, FrameStart, FrameDone, Busy;
   logic [31:0] FrameId;
`ifdef SPAD_SEQ_TIMESTAMP_EN
   logic [47:0] FrameTimestamp;
`endif

   int errors = 0;
   int checks = 0;
   int n_done, n_start;

   spad_frame_sequencer #(.MIN_FRAME_CLKS(20)) dut (
      .clk(clk), .reset(reset), .Enable(Enable), .BurstMode(BurstMode),
      .BurstFrames(BurstFrames), .CfgFrameClks(CfgFrameClks), .CfgValid(CfgValid),
      .CfgReady(CfgReady), .CfgError(CfgError), .LatchSpad(LatchSpad),
      .ResetSpad(ResetSpad), .ReadData(ReadData), .FrameStart(FrameStart),
      .FrameDone(FrameDone), .FrameId(FrameId),
      .FrameDurationCurrentClks(FrameDurationCurrentClks),
`ifdef SPAD_SEQ_TIMESTAMP_EN
      .FrameTimestamp(FrameTimestamp),
`endif
      .Busy(Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; Enable = 1'b0; BurstMode = 1'b0; BurstFrames = '0;
      CfgFrameClks = '0; CfgValid = 1'b0;
      tick(2);
      check("rst_ready", CfgReady, 1);
      check("rst_dur", FrameDurationCurrentClks, 20);
      check("rst_busy", Busy, 0);
      check("rst_id", FrameId, 0);
      check("rst_latch", LatchSpad, 0);
      reset = 1'b1;
      tick(1);

      // Continuous run: phase sequence and 20-clock period
      Enable = 1'b1;
      tick(1);
      check("f1_start", FrameStart, 1);
      check("f1_latch1", LatchSpad, 1);
      check("f1_busy", Busy, 1);
      tick(1);
      check("f1_latch2", LatchSpad, 1);
      check("f1_start_pulse", FrameStart, 0);
      tick(1);
      check("f1_pause_latch", LatchSpad, 0);
      check("f1_pause_rst", ResetSpad, 0);
      check("f1_pause_read", ReadData, 0);
      tick(1);
      check("f1_reset1", ResetSpad, 1);
      tick(1);
      check("f1_reset2", ResetSpad, 1);
      tick(1);
      check("f1_read1", ReadData, 1);
      check("f1_read1_rst", ResetSpad, 0);
      tick(13);
      check("f1_read14_done", FrameDone, 0);
      check("f1_read14_read", ReadData, 1);
      tick(1);
      check("f1_done", FrameDone, 1);
      check("f1_done_id", FrameId, 0);
      tick(1);
      check("f2_start", FrameStart, 1);
      check("f2_id", FrameId, 1);
      tick(20);
      check("f3_start", FrameStart, 1);
      check("f3_id", FrameId, 2);
      tick(20);
      check("f4_start", FrameStart, 1);
      check("f4_id", FrameId, 3);

      // Enable dropped during RESET: frame completes then IDLE
      tick(3);
      check("f4_in_reset", ResetSpad, 1);
      Enable = 1'b0;
      tick(16);
      check("f4_done", FrameDone, 1);
      tick(1);
      check("f4_idle_busy", Busy, 0);
      check("f4_idle_id", FrameId, 4);
      tick(3);
      check("f4_stay_idle", Busy, 0);

      // Burst of 3 with Enable held high
      Enable = 1'b1; BurstMode = 1'b1; BurstFrames = 16'd3;
      tick(1);
      check("b_start", FrameStart, 1);
      n_done = 0; n_start = 0;
      for (int i = 0; i < 70; i++) begin
         tick(1);
         if (FrameDone) n_done++;
         if (FrameStart) n_start++;
      end
      check("b_done_cnt", n_done, 3);
      check("b_restart_cnt", n_start, 2);
      check("b_id", FrameId, 7);
      check("b_busy", Busy, 0);
      Enable = 1'b0;
      tick(1);
      Enable = 1'b1; BurstMode = 1'b0;
      tick(1);
      check("b_rearm_start", FrameStart, 1);

      // Legal new length offered mid-READ, applied at the boundary
      tick(5);
      check("c_read1", ReadData, 1);
      check("c_ready_before", CfgReady, 1);
      CfgValid = 1'b1; CfgFrameClks = 16'd30;
      tick(1);
      check("c_ready_pending", CfgReady, 0);
      CfgFrameClks = 16'd40;
      tick(1);
      check("c_ready_held", CfgReady, 0);
      check("c_no_err", CfgError, 0);
      CfgValid = 1'b0;
      check("c_dur_unchanged", FrameDurationCurrentClks, 20);
      tick(12);
      check("c_old_len_done", FrameDone, 1);
      check("c_old_id", FrameId, 7);
      tick(1);
      check("c_new_start", FrameStart, 1);
      check("c_id_clear", FrameId, 0);
      check("c_dur_new", FrameDurationCurrentClks, 30);
      check("c_ready_back", CfgReady, 1);
      tick(28);
      check("c_long_read", ReadData, 1);
      check("c_long_not_done", FrameDone, 0);
      tick(1);
      check("c_long_done", FrameDone, 1);
      tick(1);
      check("c_next_start", FrameStart, 1);
      check("c_next_id", FrameId, 1);

      // Illegal length rejected
      CfgValid = 1'b1; CfgFrameClks = 16'd5;
      tick(1);
      check("e_err", CfgError, 1);
      check("e_ready", CfgReady, 1);
      CfgValid = 1'b0;
      tick(1);
      check("e_err_pulse", CfgError, 0);
      check("e_dur", FrameDurationCurrentClks, 30);

      // Same-value config keeps numbering
      CfgValid = 1'b1; CfgFrameClks = 16'd30;
      tick(1);
      check("s_ready", CfgReady, 0);
      CfgValid = 1'b0;
      tick(26);
      check("s_done", FrameDone, 1);
      tick(1);
      check("s_start", FrameStart, 1);
      check("s_id_kept", FrameId, 2);
      check("s_ready_back", CfgReady, 1);

      // Reset mid-READ with a pending config
      tick(10);
      check("r_in_read", ReadData, 1);
      CfgValid = 1'b1; CfgFrameClks = 16'd40;
      tick(1);
      CfgValid = 1'b0;
      check("r_pending", CfgReady, 0);
      #4;
      reset = 1'b0; Enable = 1'b0;
      #1;
      check("r_async_read", ReadData, 0);
      check("r_async_id", FrameId, 0);
      check("r_async_busy", Busy, 0);
      check("r_async_ready", CfgReady, 1);
      check("r_async_dur", FrameDurationCurrentClks, 20);
      tick(2);
      reset = 1'b1;
      tick(3);
      check("r_pend_lost", FrameDurationCurrentClks, 20);
      check("r_idle", Busy, 0);

      // Config applied from IDLE on the next clock
      CfgValid = 1'b1; CfgFrameClks = 16'd25;
      tick(1);
      CfgValid = 1'b0;
      check("i_ready_low", CfgReady, 0);
      tick(1);
      check("i_dur", FrameDurationCurrentClks, 25);
      check("i_ready", CfgReady, 1);

      // BurstFrames = 0 runs a single frame
      Enable = 1'b1; BurstMode = 1'b1; BurstFrames = 16'd0;
      tick(1);
      check("z_start", FrameStart, 1);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (FrameDone) n_done++;
      end
      check("z_done_cnt", n_done, 1);
      check("z_busy", Busy, 0);
      check("z_id", FrameId, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spad_frame_sequencer.md
Name: spad_frame_sequencer

Overview:
- Parametrised successor to the fixed SPAD frame controller.
- Sequences LATCH -> PAUSE -> RESET -> READ per frame, with configurable phase lengths and programmable frame length.
- Supports continuous or N-frame burst operation, start/stop control, and a valid/ready handshake for frame-length changes that are applied only at frame boundaries.
- Sits between the register/AXI-lite block and the SPAD array plus read_process_manager.

Parameters:
- DUR_BITS, 16: width of all duration counters and the frame-length config.
- LATCH_CLKS, 2: LATCH phase length in clocks (>=1).
- PAUSE_CLKS, 1: PAUSE phase length in clocks (>=1).
- RESET_CLKS, 2: RESET phase length in clocks (>=1).
- MIN_FRAME_CLKS, 6667: minimum legal frame length; also the reset default frame length.
- FRAME_ID_BITS, 32: FrameId width.
- BURST_BITS, 16: BurstFrames width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- Enable  in  1  run request (level)
- BurstMode  in  1  0 = continuous, 1 = burst of BurstFrames frames
- BurstFrames  in  BURST_BITS  frame count for burst mode
- CfgFrameClks  in  DUR_BITS  requested frame length
- CfgValid  in  1  config offer
- CfgReady  out  1  config accepted when CfgValid & CfgReady
- CfgError  out  1  one-cycle pulse: request rejected
- LatchSpad  out  1  high during LATCH
- ResetSpad  out  1  high during RESET
- ReadData  out  1  high during READ (to read_process_manager)
- FrameStart  out  1  pulse on the first LATCH cycle
- FrameDone  out  1  pulse on the last READ cycle
- FrameId  out  FRAME_ID_BITS  completed-frame counter
- FrameDurationCurrentClks  out  DUR_BITS  active frame length
- Busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; all outputs 0 except CfgReady = 1 and FrameDurationCurrentClks = MIN_FRAME_CLKS; no pending config; burst counter 0. All outputs are registered.
- States: IDLE, LATCH, PAUSE, RESET, READ.
- Phase lengths: each phase lasts exactly its length in clocks. READ length = cur_frame - (LATCH_CLKS + PAUSE_CLKS + RESET_CLKS). A frame is therefore exactly cur_frame clocks.
- Start: Enable high in IDLE -> LATCH on the next clock. On that entry, BurstMode and BurstFrames are sampled; BurstFrames = 0 is treated as 1.
- Leaving READ, the next state is IDLE if any of the following holds, else LATCH:
  - Enable is low;
  - burst mode and the remaining count reaches 0;
  - burst completed and Enable is still high (a new run requires Enable to fall and rise again).
- Enable falling mid-frame never truncates the frame; the current frame completes.
- FrameId increments by 1 at FrameDone and wraps modulo 2^FRAME_ID_BITS.
- Config handshake:
  - CfgReady is low while a pending value is held.
  - An accepted value is legal if MIN_FRAME_CLKS <= CfgFrameClks <= 2^DUR_BITS-1.
  - An illegal value pulses CfgError on the next cycle and is discarded; CfgReady stays high.
  - A legal value is held as pending and applied on the cycle that enters LATCH from READ, or on the next clock when in IDLE. CfgReady then returns high.
- Applying pending config:
  - If the value differs from cur_frame, FrameId is cleared to 0. This takes priority over a simultaneous FrameDone increment.
  - If the value is equal, FrameId is unchanged.
- Config is never applied mid-frame, so a frame in progress keeps its length.
- Reset asserted mid-frame: all outputs return to reset values immediately, and any pending config is lost.

Optional Feature:
- Macro SPAD_SEQ_TIMESTAMP_EN.
- When defined:
  - adds a free-running 48-bit cycle counter (cleared by reset);
  - adds output FrameTimestamp [47:0], loaded with the counter value at each FrameStart;
  - FrameTimestamp holds its value until the next FrameStart and resets to 0.
- When undefined: no counter and no port; all other behaviour is identical.

Decomposition:
- Shared package/header spad_controller_definitions.vh holds:
  - state encodings (one-hot, 5 states);
  - MIN_FRAME_CLKS default;
  - DUR_BITS default.
- One natural sub-module: spad_phase_timer. It is a loadable down-counter of width DUR_BITS with a load value, a load strobe and a `last` flag, and is reused for every phase.

Test Plan:
- Reset, Enable=1, BurstMode=0 -> FrameStart every 6667 clks; LatchSpad 2 clks, 1 idle clk, ResetSpad 2 clks, ReadData 6662 clks; FrameId 1, 2, 3.
- BurstMode=1, BurstFrames=3, Enable held high -> exactly 3 FrameDone pulses, FrameId=3, then IDLE with Busy=0; no restart until Enable toggles.
- CfgFrameClks=10000 sent mid-READ of frame 2 -> frame 2 stays 6667 clks; frame 3 is 10000 clks with ReadData 9995; FrameId clears to 0 at frame 3 start; FrameDurationCurrentClks=10000.
- CfgFrameClks=100 -> CfgError pulse; cur frame stays 6667; FrameId continues.
- Same-value config (6667) -> no FrameId clear. Second CfgValid while one is pending -> CfgReady=0 until the boundary.
- Enable dropped mid-RESET -> the frame completes, FrameDone fires, then IDLE. Reset asserted mid-READ -> all outputs 0 asynchronously and FrameId=0.
